// File: rtl/div_seq_if.sv
// Bus between the sequential divider and its two neighbours: the
// requesting datapath/control (start/op/operands in, busy/done/result out)
// and the shared 64-bit ALU adder (A/B/SUB out, S/COUT back).
// slave  = divider side, master = requester + adder side.
interface div_seq_if #(
  parameter int XLEN = 64
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] add_a;
  logic [XLEN-1:0] add_b;
  logic            add_sub;
  logic [XLEN-1:0] add_s;
  logic            add_cout;

  modport slave (
    input  start, op, dividend, divisor, add_s, add_cout,
    output busy, done, result, add_a, add_b, add_sub
  );

  modport master (
    output start, op, dividend, divisor, add_s, add_cout,
    input  busy, done, result, add_a, add_b, add_sub
  );
endinterface

// File: rtl/div_seq_unit.sv
// Iterative restoring divider for RV64M DIV/DIVU/REM/REMU.
// One trial subtraction per cycle on the shared ALU adder, XLEN iterations,
// then a sign-fixup cycle and a one-cycle done pulse. Division by zero and
// signed overflow are resolved at capture and skip the iteration phase.
module div_seq_unit #(
  parameter int XLEN = 64
) (
  input  logic     clk,
  input  logic     rst_n,
  div_seq_if.slave bus
);

  localparam int              CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] SMIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_SIGN,
    S_DONE
  } state_t;

  state_t          state_q;
  logic            sel_rem_q;   // op[1]: return remainder instead of quotient
  logic            qneg_q;
  logic            rneg_q;
  logic [XLEN-1:0] dvs_q;       // |divisor| for the iteration
  logic [XLEN-1:0] q_q;         // dividend shifting out / quotient shifting in
  logic [XLEN-1:0] rem_q;       // partial remainder
  logic [CNT_W-1:0] cnt_q;
  logic            busy_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;

  // Operand conditioning at capture
  logic            dvd_neg;
  logic            dvs_neg;
  logic [XLEN-1:0] dvd_abs;
  logic [XLEN-1:0] dvs_abs;
  logic            div_zero;
  logic            sgn_ovf;

  assign dvd_neg  = ~bus.op[0] & bus.dividend[XLEN-1];
  assign dvs_neg  = ~bus.op[0] & bus.divisor[XLEN-1];
  assign dvd_abs  = dvd_neg ? (~bus.dividend + XLEN'(1)) : bus.dividend;
  assign dvs_abs  = dvs_neg ? (~bus.divisor + XLEN'(1)) : bus.divisor;
  assign div_zero = (bus.divisor == '0);
  assign sgn_ovf  = ~bus.op[0] & (bus.dividend == SMIN) & (bus.divisor == '1);

  // One restoring step: {msb, r_shift} is the 65-bit shifted partial remainder.
  // A set msb means r_shift+2^XLEN already exceeds any divisor, so the bit is 1
  // regardless of the adder's borrow and the XLEN-bit difference is exact.
  logic            in_iter;
  logic            msb;
  logic [XLEN-1:0] r_shift;
  logic            qbit;

  assign in_iter = (state_q == S_ITER);
  assign msb     = rem_q[XLEN-1];
  assign r_shift = {rem_q[XLEN-2:0], q_q[XLEN-1]};
  assign qbit    = msb | bus.add_cout;

  // The adder answers in the same cycle, so its inputs must be combinational
  // from current state; they are forced to zero outside the iteration phase.
  assign bus.add_a   = in_iter ? r_shift : '0;
  assign bus.add_b   = in_iter ? dvs_q : '0;
  assign bus.add_sub = in_iter;

  // Sign fixup of quotient and remainder
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;

  assign q_fix = qneg_q ? (~q_q + XLEN'(1)) : q_q;
  assign r_fix = rneg_q ? (~rem_q + XLEN'(1)) : rem_q;

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sel_rem_q <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      dvs_q     <= '0;
      q_q       <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            sel_rem_q <= bus.op[1];
            busy_q    <= 1'b1;
            if (div_zero) begin
              // Quotient all ones, remainder = raw dividend; no sign fixup.
              q_q     <= '1;
              rem_q   <= bus.dividend;
              qneg_q  <= 1'b0;
              rneg_q  <= 1'b0;
              state_q <= S_SIGN;
            end else if (sgn_ovf) begin
              q_q     <= bus.dividend;
              rem_q   <= '0;
              qneg_q  <= 1'b0;
              rneg_q  <= 1'b0;
              state_q <= S_SIGN;
            end else begin
              q_q     <= dvd_abs;
              rem_q   <= '0;
              dvs_q   <= dvs_abs;
              qneg_q  <= dvd_neg ^ dvs_neg;
              rneg_q  <= dvd_neg;
              cnt_q   <= CNT_W'(XLEN - 1);
              state_q <= S_ITER;
            end
          end
        end
        S_ITER: begin
          q_q   <= {q_q[XLEN-2:0], qbit};
          rem_q <= qbit ? bus.add_s : r_shift;
          if (cnt_q == '0) begin
            state_q <= S_SIGN;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_SIGN: begin
          result_q <= sel_rem_q ? r_fix : q_fix;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_unit.sv
// Self-checking bench for div_seq_unit: models the shared adder, runs the
// directed RV64M corner cases, a mid-iteration start, an asynchronous abort,
// a back-to-back pair and a randomized batch against an arithmetic model.
module tb_div_seq_unit;

  localparam int          XLEN = 64;
  localparam logic [63:0] SMIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  div_seq_if #(.XLEN(XLEN)) bus ();

  div_seq_unit #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Shared ALU adder: S = A + (SUB ? ~B + 1 : B), COUT = carry out
  assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_a}
                                   + {1'b0, (bus.add_sub ? ~bus.add_b : bus.add_b)}
                                   + 65'(bus.add_sub);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Architectural RV64M result
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [63:0] a,
                                             input logic [63:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic [63:0]        q;
    logic [63:0]        r;
    sa = a;
    sb = b;
    if (b == 64'd0) begin
      q = ONES;
      r = a;
    end else if (!op[0] && a == SMIN && b == ONES) begin
      q = a;
      r = 64'd0;
    end else if (!op[0]) begin
      q = 64'(sa / sb);
      r = 64'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [63:0] a,
                                    input logic [63:0] b);
    return (b == 64'd0) || (!op[0] && a == SMIN && b == ONES);
  endfunction

  // Issue one op at a negedge; count cycles (negedges) until done.
  // poke_at > 0 pulses start with unrelated operands on that cycle.
  task automatic run_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                        input int poke_at, input bit iter_exp,
                        output int lat, output int busy_cnt, output logic [63:0] res);
    bus.op       = op;
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    lat      = 0;
    busy_cnt = 0;
    res      = '0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == poke_at) begin
        bus.start    = 1'b1;
        bus.op       = 2'($urandom_range(0, 3));
        bus.dividend = {$urandom, $urandom};
        bus.divisor  = {$urandom, $urandom} | 64'd1;
      end else begin
        bus.start = 1'b0;
      end
      if (k == 5 && iter_exp) check("add_sub_iter", 64'(bus.add_sub), 64'd1);
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        lat = k;
        res = bus.result;
        break;
      end
    end
  endtask

  task automatic do_op(input string tag, input logic [1:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp_res, input int poke_at);
    int          lat;
    int          busy_cnt;
    int          exp_lat;
    logic [63:0] res;
    bit          spec;
    spec    = is_special(op, a, b);
    exp_lat = spec ? 2 : 66;
    run_op(op, a, b, poke_at, !spec, lat, busy_cnt, res);
    $display("op=%0d a=%h b=%h -> res=%h lat=%0d (%s)", op, a, b, res, lat, tag);
    check({tag, ":result"}, res, exp_res);
    check({tag, ":latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ":busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
    @(negedge clk);
    check({tag, ":done_pulse"}, 64'(bus.done), 64'd0);
    check({tag, ":busy_after"}, 64'(bus.busy), 64'd0);
    check({tag, ":add_idle"}, {63'd0, bus.add_sub} | bus.add_a | bus.add_b, 64'd0);
  endtask

  initial begin
    int          lat;
    int          busy_cnt;
    int          k1;
    int          k2;
    int          done_seen;
    logic [63:0] res;
    logic [63:0] r1;
    logic [63:0] r2;
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  op;

    total        = 0;
    bad          = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.op       = 2'd0;
    bus.dividend = '0;
    bus.divisor  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst:busy", 64'(bus.busy), 64'd0);
    check("rst:done", 64'(bus.done), 64'd0);
    check("rst:result", bus.result, 64'd0);
    check("rst:add", {63'd0, bus.add_sub} | bus.add_a | bus.add_b, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    do_op("divu_100_7", 2'b01, 64'd100, 64'd7, 64'd14, 0);
    do_op("remu_100_7", 2'b11, 64'd100, 64'd7, 64'd2, 0);
    do_op("div_m7_2", 2'b00, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    do_op("rem_m7_2", 2'b10, -64'sd7, 64'd2, ONES, 0);
    do_op("rem_7_m2", 2'b10, 64'd7, -64'sd2, 64'd1, 0);
    do_op("divu_max_1", 2'b01, ONES, 64'd1, ONES, 0);
    do_op("remu_msb", 2'b11, ONES, SMIN, 64'h7FFF_FFFF_FFFF_FFFF, 0);
    do_op("div_by0", 2'b00, 64'd5, 64'd0, ONES, 0);
    do_op("rem_by0", 2'b10, 64'd5, 64'd0, 64'd5, 0);
    do_op("div_ovf", 2'b00, SMIN, ONES, SMIN, 0);
    do_op("rem_ovf", 2'b10, SMIN, ONES, 64'd0, 0);
    do_op("divu_min_ones", 2'b01, SMIN, ONES, 64'd0, 0);

    // start pulsed mid-iteration must be ignored
    do_op("poke_mid_iter", 2'b00, 64'd1000, -64'sd33, ref_result(2'b00, 64'd1000, -64'sd33), 10);

    // Asynchronous abort around iteration 30
    bus.op       = 2'b01;
    bus.dividend = 64'd123456789;
    bus.divisor  = 64'd97;
    bus.start    = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    $display("abort: busy=%0d done=%0d result=%h", bus.busy, bus.done, bus.result);
    check("abort:busy", 64'(bus.busy), 64'd0);
    check("abort:done", 64'(bus.done), 64'd0);
    check("abort:result", bus.result, 64'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_seen++;
    end
    check("abort:no_done", 64'(done_seen), 64'd0);

    // Back-to-back: start held high through the IDLE cycle after done
    bus.op       = 2'b01;
    bus.dividend = 64'd1000;
    bus.divisor  = 64'd9;
    bus.start    = 1'b1;
    k1 = 0;
    k2 = 0;
    r1 = '0;
    r2 = '0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.op       = 2'b11;
        bus.dividend = 64'd1000;
        bus.divisor  = 64'd9;
      end
      if (k1 != 0 && k == k1 + 2) bus.start = 1'b0;
      if (bus.done) begin
        if (k1 == 0) begin
          k1 = k;
          r1 = bus.result;
        end else begin
          k2 = k;
          r2 = bus.result;
          break;
        end
      end
    end
    bus.start = 1'b0;
    $display("b2b: done at %0d and %0d, results %h %h", k1, k2, r1, r2);
    check("b2b:first_lat", 64'(k1), 64'd66);
    check("b2b:spacing", 64'(k2 - k1), 64'd67);
    check("b2b:first_res", r1, 64'd111);
    check("b2b:second_res", r2, 64'd1);
    @(negedge clk);

    // Randomized batch against the arithmetic model
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: ;
        1: b = 64'($urandom_range(1, 20)) * (($urandom_range(0, 1) == 1) ? ONES : 64'd1);
        2: b = 64'd0;
        3: begin a = SMIN; b = ONES; end
        4: b = b >> $urandom_range(0, 63);
        default: a = a >> $urandom_range(0, 63);
      endcase
      do_op("rand", op, a, b, ref_result(op, a, b), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
